// File: rtl/uart_tx.sv
// uart_tx: one-bit-per-clock UART frame transmitter.
// Frame: start (0), width data bits LSB first, optional parity, stop (1).
// Define UART_TX_TWO_STOP_BITS_EN to send two stop bits instead of one.
// Tx_out and Busy come straight from flops; they are decoded from the
// next state so they change on the same edge as the state register.
module uart_tx #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Parity_type,
    input  logic             Parity_EN,
    input  logic             Data_valid,
    input  logic [width-1:0] Data,
    output logic             Busy,
    output logic             Tx_out
);

    localparam int CNT_W = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [width-1:0]   data_q;
    logic               par_en_q;
    logic               par_type_q;
    logic               load;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;

    // Next-state logic plus decode of the line/busy value for the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Data_valid) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == CNT_W'(width - 1)) begin
                    state_d = par_en_q ? PARITY : STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
                cnt_d   = '0;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_BITS_EN
                // cnt_q tracks which of the two stop cycles is on the line.
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = data_q[cnt_d];
                busy_d = 1'b1;
            end
            PARITY: begin
                // Even: XOR of data bits; odd: its inverse.
                tx_d   = (^data_q) ^ par_type_q;
                busy_d = 1'b1;
            end
            STOP: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // State, frame configuration and registered outputs; reset abandons any frame.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (load) begin
                data_q     <= Data;
                par_en_q   <= Parity_EN;
                par_type_q <= Parity_type;
            end
        end
    end

    assign Tx_out = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus randomized frames
// compared cycle by cycle against a frame model built from the frame rules.
module tb_uart_tx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         Parity_type;
    logic         Parity_EN;
    logic         Data_valid;
    logic [W-1:0] Data;
    logic         Busy;
    logic         Tx_out;

    int checks = 0;
    int errors = 0;

    uart_tx #(.width(W)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Parity_type (Parity_type),
        .Parity_EN   (Parity_EN),
        .Data_valid  (Data_valid),
        .Data        (Data),
        .Busy        (Busy),
        .Tx_out      (Tx_out)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected line sequence for one frame, straight from the frame rules.
    function automatic void build_frame(input logic [W-1:0] d, input logic pe,
                                        input logic pt, output logic q[$]);
        int ones;
        q.delete();
        q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < W; i++) begin
            q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pe) q.push_back(((ones % 2) == 1) ^ pt);
        q.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_BITS_EN
        q.push_back(1'b1);
`endif
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_tx", Tx_out, 1'b1);
            chk("idle_busy", Busy, 1'b0);
        end
    endtask

    // Offer one word and follow the whole frame. pulse_k >= 0 raises Data_valid
    // during frame cycle pulse_k; hold keeps Data_valid high throughout.
    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt,
                        input int pulse_k, input bit hold);
        logic exp_q[$];
        build_frame(d, pe, pt, exp_q);
        Data        = d;
        Parity_EN   = pe;
        Parity_type = pt;
        Data_valid  = 1'b1;
        tick();
        // Scramble the inputs: the latched copy must carry the frame.
        Data        = ~d;
        Parity_EN   = ~pe;
        Parity_type = ~pt;
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("tx[%0d] d=%h pe=%b pt=%b", k, d, pe, pt), Tx_out, exp_q[k]);
            chk($sformatf("busy[%0d]", k), Busy, 1'b1);
            if (hold || k == pulse_k) Data_valid = 1'b1;
            else Data_valid = 1'b0;
            tick();
        end
        if (!hold) Data_valid = 1'b0;
        chk("post_tx", Tx_out, 1'b1);
        chk("post_busy", Busy, 1'b0);
    endtask

    initial begin
        Reset       = 1'b1;
        Parity_type = 1'b0;
        Parity_EN   = 1'b0;
        Data_valid  = 1'b0;
        Data        = '0;

        // Reset held for two edges
        tick();
        tick();
        chk("rst_tx", Tx_out, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        Reset = 1'b0;
        idle(20);

        // Directed frames: even parity, odd parity, no parity
        send(8'h55, 1'b1, 1'b0, -1, 1'b0);
        idle(2);
        send(8'hAA, 1'b1, 1'b1, -1, 1'b0);
        idle(2);
        send(8'hF0, 1'b0, 1'b0, -1, 1'b0);
        idle(2);

        // Mid-frame pulse 7 cycles after acceptance is ignored, no second frame
        send(8'h3C, 1'b1, 1'b0, 6, 1'b0);
        idle(5);

        // Pulse during the stop cycle is ignored
        send(8'h81, 1'b0, 1'b1, W + 1, 1'b0);
        idle(3);

        // Back-to-back: accepted in the first idle cycle after stop
        send(8'h12, 1'b1, 1'b1, -1, 1'b0);
        send(8'hE7, 1'b1, 1'b0, -1, 1'b0);
        idle(2);

        // Data_valid held high: one frame per acceptance, re-accepted in idle
        send(8'hC3, 1'b0, 1'b0, -1, 1'b1);
        send(8'h5A, 1'b1, 1'b1, -1, 1'b0);
        idle(3);

        // Reset during DATA abandons the frame
        Data       = 8'hFF;
        Parity_EN  = 1'b1;
        Data_valid = 1'b1;
        tick();
        Data_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", Busy, 1'b1);
        Reset = 1'b1;
        tick();
        chk("midrst_tx", Tx_out, 1'b1);
        chk("midrst_busy", Busy, 1'b0);
        Reset = 1'b0;
        idle(3);
        send(8'h69, 1'b1, 1'b0, -1, 1'b0);
        idle(1);

        // Randomized frames with random gaps and stray strobes
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] d;
            logic pe, pt;
            int pk;
            d  = W'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            pk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : -1;
            send(d, pe, pt, pk, 1'b0);
            idle(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name:
uart_tx

Overview:
- Serial transmitter for the low-power communication system.
- Accepts a parallel word on a one-cycle Data_valid strobe and sends one UART frame: start bit, data LSB-first, optional parity, stop bit.
- Sends one bit per CLK cycle. The baud clock is supplied externally as CLK.
- Busy tells the upstream producer when a new word may be offered.

Parameters:
- width, 8, number of data bits per frame (legal range 5..16).

Ports:
- CLK  input  1  bit clock, rising-edge active.
- Reset  input  1  synchronous, active-high reset.
- Parity_type  input  1  0 = even parity, 1 = odd parity.
- Parity_EN  input  1  1 = insert parity bit after data.
- Data_valid  input  1  one-cycle strobe: Data is valid, request transmission.
- Data  input  width  word to transmit.
- Busy  output  1  high while a frame is being transmitted.
- Tx_out  output  1  serial line; idles high.

Behaviour:
- Interface: one clock (CLK). Reset is synchronous and active-high.
- Reset: when Reset=1 at a rising CLK edge:
  - FSM goes to IDLE.
  - Tx_out=1, Busy=0.
  - Shift register and parity config are cleared.
  - Reset overrides everything, including mid-frame; the partial frame is abandoned.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Tx_out=1, Busy=0.
  - If Data_valid=1 at an edge: latch Data, Parity_EN and Parity_type, then go to START.
  - Data, Parity_EN and Parity_type may change afterwards without affecting the frame.
- START: Tx_out=0, Busy=1. Lasts one cycle, then DATA.
- DATA:
  - Tx_out = latched Data[i] for i = 0..width-1, LSB first, one cycle per bit.
  - A bit counter, sized for width, selects the bit.
  - After bit width-1: go to PARITY if the latched Parity_EN=1, else STOP.
- PARITY: one cycle.
  - Even (type 0): Tx_out = XOR of data bits.
  - Odd (type 1): Tx_out = inverted XOR.
- STOP: Tx_out=1, Busy=1 for one cycle, then IDLE.
- Latency and frame length:
  - Data_valid sampled at edge N gives the start bit on Tx_out from edge N+1.
  - Frame length is width+3 cycles with parity, width+2 without.
- Busy rises at the same edge as the start bit and falls at the edge that returns to IDLE.
- Data_valid while Busy=1 (including the STOP cycle) is ignored and not queued.
- Back-to-back: a Data_valid in the first IDLE cycle after STOP is accepted. Minimum inter-frame gap is 1 idle cycle.
- Data_valid held high in IDLE starts exactly one frame per acceptance. Another frame starts only if it is still high on a later IDLE cycle.

Optional Feature:
- Macro UART_TX_TWO_STOP_BITS_EN.
- When defined: STOP lasts two cycles (Tx_out=1, Busy=1 both). Frame length is width+4 with parity, width+3 without.
- When undefined: single stop bit, as specified above.

Test Plan:
- Reset held 1 for 2 edges, then 0 -> Tx_out=1, Busy=0; idle remains high for 20 cycles with Data_valid=0.
- Data=0x55, Parity_EN=1, Parity_type=0, one-cycle Data_valid -> from next edge Tx_out = 0,1,0,1,0,1,0,1,0,0,1 (start, data LSB-first, even parity 0, stop). Busy=1 for those 11 cycles, then 0.
- Data=0xAA, Parity_EN=1, Parity_type=1 -> Tx_out = 0,0,1,0,1,0,1,0,1,1,1 (odd parity bit 1). Data changed to 0x00 one cycle after acceptance has no effect on the frame.
- Data=0xF0, Parity_EN=0 -> 10-cycle frame 0,0,0,0,0,1,1,1,1,1; Busy high 10 cycles.
- Mid-frame Data_valid pulse 7 cycles after the first acceptance -> ignored; the frame is unchanged and no second frame follows. A pulse in the first cycle after Busy falls -> a new frame starts on the next edge.
- Reset=1 during the DATA state -> at the next edge Tx_out=1, Busy=0. A subsequent Data_valid then starts a clean frame.
